// File: rtl/multdiv_sequencer.sv
// ============================================================================
// multdiv_sequencer
// ----------------------------------------------------------------------------
// Control FSM for the shared iterative multiply/divide datapath. A one-cycle
// start pulse from decode latches the operation type, spends one cycle loading
// operands, runs the datapath for MULT_CYCLES or DIV_CYCLES steps, then emits a
// one-cycle result-ready pulse. A divide by zero skips the run phase and
// reports an exception alongside the ready pulse. A start seen in any state
// aborts whatever is in flight and restarts in LOAD.
//
// Ports:
//   clock           in   single clock, all state on posedge
//   reset           in   synchronous, active-high
//   ctrl_MULT       in   start-multiply pulse (wins if ctrl_DIV also set)
//   ctrl_DIV        in   start-divide pulse
//   data_operandB   in   divisor/multiplier, sampled on start for zero check
//   dp_zero_rem     in   datapath: remaining multiplier bits all zero
//   op_latch_en     out  datapath loads operand registers this cycle
//   step_en         out  datapath performs one iteration this cycle
//   step_count      out  0-based index of the current step
//   is_div          out  1 = divide in flight, 0 = multiply
//   busy            out  FSM not idle
//   stall           out  hold pipeline while loading/running
//   data_resultRDY  out  one-cycle pulse, result valid on datapath output
//   data_exception  out  valid with data_resultRDY; 1 = divide by zero
//
// Configuration macro:
//   MULTDIV_EARLY_EXIT_EN  when defined, a multiply finishes as soon as the
//                          datapath reports no remaining multiplier bits
//                          (after at least one step). When undefined,
//                          dp_zero_rem is ignored.
// ============================================================================
module multdiv_sequencer #(
    parameter int unsigned MULT_CYCLES = 16,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [31:0]      data_operandB,
    input  logic             dp_zero_rem,
    output logic             op_latch_en,
    output logic             step_en,
    output logic [CNT_W-1:0] step_count,
    output logic             is_div,
    output logic             busy,
    output logic             stall,
    output logic             data_resultRDY,
    output logic             data_exception
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] L_MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_step_count;
    logic             r_is_div;
    logic             r_div0;

    logic             w_start;
    logic             w_start_div;
    logic             w_last_step;
    logic             w_early_exit;

`ifdef MULTDIV_EARLY_EXIT_EN
    // Only multiplies can finish early, and only once a step has been taken.
    assign w_early_exit = ~r_is_div & dp_zero_rem & (r_step_count != '0);
`else
    logic w_unused_zero_rem;
    assign w_unused_zero_rem = dp_zero_rem;
    assign w_early_exit      = 1'b0;
`endif

    assign w_start     = ctrl_MULT | ctrl_DIV;
    assign w_start_div = ctrl_DIV & ~ctrl_MULT;
    assign w_last_step = (r_step_count == (r_is_div ? L_DIV_LAST : L_MULT_LAST));

    // Next-state: a start pulse overrides every state, including DONE.
    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_IDLE;
                S_LOAD:  w_next_state = r_div0 ? S_DONE : S_RUN;
                S_RUN:   w_next_state = (w_last_step || w_early_exit) ? S_DONE : S_RUN;
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Outputs are a function of the current state only.
    always_comb begin
        op_latch_en    = 1'b0;
        step_en        = 1'b0;
        stall          = 1'b0;
        data_resultRDY = 1'b0;
        data_exception = 1'b0;
        busy           = (r_state != S_IDLE);
        step_count     = busy ? r_step_count : '0;
        is_div         = busy & r_is_div;
        case (r_state)
            S_LOAD: begin
                op_latch_en = 1'b1;
                stall       = 1'b1;
            end
            S_RUN: begin
                step_en = 1'b1;
                stall   = 1'b1;
            end
            S_DONE: begin
                data_resultRDY = 1'b1;
                data_exception = r_div0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_step_count <= '0;
            r_is_div     <= 1'b0;
            r_div0       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_is_div     <= w_start_div;
                r_div0       <= w_start_div & (data_operandB == '0);
                r_step_count <= '0;
            end else if (r_state == S_RUN && w_next_state == S_RUN) begin
                // Counter holds on the final step so DONE still reports it.
                r_step_count <= r_step_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// ============================================================================
// tb_multdiv_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for multdiv_sequencer. The reference model tracks each
// operation only by its start cycle, type and the cycle its ready pulse is
// due; every output for a cycle is derived from the offset to the start cycle.
// All outputs are compared against that model at every negative clock edge.
// Directed scenarios pin ready latencies with literal cycle counts, then a
// randomized phase exercises starts, aborts, zero divisors and resets.
// ============================================================================
module tb_multdiv_sequencer;

    localparam int MULT_N = 16;
    localparam int DIV_N  = 32;

`ifdef MULTDIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandB;
    logic        dp_zero_rem;
    logic        op_latch_en;
    logic        step_en;
    logic [5:0]  step_count;
    logic        is_div;
    logic        busy;
    logic        stall;
    logic        data_resultRDY;
    logic        data_exception;

    multdiv_sequencer #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N),
        .CNT_W      (6)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandB (data_operandB),
        .dp_zero_rem   (dp_zero_rem),
        .op_latch_en   (op_latch_en),
        .step_en       (step_en),
        .step_count    (step_count),
        .is_div        (is_div),
        .busy          (busy),
        .stall         (stall),
        .data_resultRDY(data_resultRDY),
        .data_exception(data_exception)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: operation described by start cycle and ready cycle.
    int  cyc     = 0;
    bit  m_active = 1'b0;
    int  m_t0     = 0;
    bit  m_isdiv  = 1'b0;
    bit  m_div0   = 1'b0;
    int  m_done   = 0;
    logic [12:0] e_vec;

    // Observation helpers for the literal checks.
    int n_rdy    = 0;
    int n_step   = 0;
    int last_rdy = -1;
    bit last_exc = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advances the model across the edge ending cycle cyc, using the inputs
    // applied during that cycle, and forms the expected outputs of cycle cyc+1.
    task automatic model_step();
        int c;
        int k;
        int n;
        bit op_e, se_e, busy_e, stall_e, rdy_e, exc_e, isd_e;
        int step_e;
        c = cyc;
        if (reset) begin
            m_active = 1'b0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            m_active = 1'b1;
            m_t0     = c;
            m_isdiv  = ctrl_DIV && !ctrl_MULT;
            m_div0   = m_isdiv && (data_operandB == 32'd0);
            n        = m_isdiv ? DIV_N : MULT_N;
            m_done   = m_div0 ? c + 2 : c + n + 2;
        end else if (m_active && c == m_done) begin
            m_active = 1'b0;
        end else if (EARLY && m_active && !m_isdiv && c >= m_t0 + 2 && c < m_done
                     && (c - m_t0 - 2) >= 1 && dp_zero_rem) begin
            m_done = c + 1;
        end
        cyc = c + 1;

        op_e = 0; se_e = 0; busy_e = 0; stall_e = 0; rdy_e = 0; exc_e = 0;
        isd_e = 0; step_e = 0;
        if (m_active) begin
            k      = cyc - m_t0;
            busy_e = 1;
            isd_e  = m_isdiv;
            if (cyc == m_done) begin
                rdy_e  = 1;
                exc_e  = m_div0;
                step_e = m_div0 ? 0 : m_done - m_t0 - 3;
            end else if (k == 1) begin
                op_e    = 1;
                stall_e = 1;
            end else begin
                se_e    = 1;
                stall_e = 1;
                step_e  = k - 2;
            end
        end
        e_vec = {op_e, se_e, step_e[5:0], isd_e, busy_e, stall_e, rdy_e, exc_e};
    endtask

    // One clock cycle: update model on the rising edge, compare on the falling.
    task automatic tick();
        logic [12:0] a_vec;
        @(posedge clock);
        model_step();
        @(negedge clock);
        a_vec = {op_latch_en, step_en, step_count, is_div, busy, stall,
                 data_resultRDY, data_exception};
        n_cmp++;
        if (a_vec !== e_vec) begin
            n_fail++;
            $display("FAIL outputs cycle %0d: got %h, expected %h (op,step,cnt[6],div,busy,stall,rdy,exc)",
                     cyc, a_vec, e_vec);
        end
        if (data_resultRDY) begin
            n_rdy++;
            last_rdy = cyc;
            last_exc = data_exception;
        end
        if (step_en) n_step++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_op(input bit m, input bit d, input logic [31:0] b, output int s0);
        s0            = cyc;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandB = b;
        tick();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic clear_obs();
        n_rdy    = 0;
        n_step   = 0;
        last_rdy = -1;
        last_exc = 1'b0;
    endtask

    initial begin
        int s0;
        int dummy;
        int r;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandB = 32'd0;
        dp_zero_rem   = 1'b0;
        run(3);
        check("reset_outputs_zero",
              int'({op_latch_en, step_en, step_count, is_div, busy, stall,
                    data_resultRDY, data_exception}), 0);
        reset = 1'b0;
        run(2);

        // Multiply: ready 18 cycles after the start.
        clear_obs();
        start_op(1'b1, 1'b0, 32'd9, s0);
        run(22);
        check("mult_ready_cycle", last_rdy - s0, 18);
        check("mult_ready_count", n_rdy, 1);
        check("mult_exception", int'(last_exc), 0);
        check("mult_step_count", n_step, 16);

        // Divide by 5: ready at 34.
        clear_obs();
        start_op(1'b0, 1'b1, 32'd5, s0);
        run(38);
        check("div_ready_cycle", last_rdy - s0, 34);
        check("div_step_count", n_step, 32);

        // Divide by zero: ready with exception at 2, no steps.
        clear_obs();
        start_op(1'b0, 1'b1, 32'd0, s0);
        run(5);
        check("div0_ready_cycle", last_rdy - s0, 2);
        check("div0_exception", int'(last_exc), 1);
        check("div0_no_steps", n_step, 0);

        // Multiply aborted by a divide started 7 cycles later.
        clear_obs();
        start_op(1'b1, 1'b0, 32'd3, s0);
        run(6);
        start_op(1'b0, 1'b1, 32'd7, dummy);
        run(40);
        check("abort_ready_cycle", last_rdy - s0, 41);
        check("abort_ready_count", n_rdy, 1);

        // Both starts together behave as a multiply.
        clear_obs();
        start_op(1'b1, 1'b1, 32'd0, s0);
        run(22);
        check("both_ready_cycle", last_rdy - s0, 18);
        check("both_no_exception", int'(last_exc), 0);

        // Reset during RUN, then a fresh multiply.
        clear_obs();
        start_op(1'b1, 1'b0, 32'd1, s0);
        run(9);
        reset = 1'b1;
        tick();
        check("reset_mid_run_busy", int'(busy), 0);
        reset = 1'b0;
        tick();
        check("reset_mid_run_no_ready", n_rdy, 0);
        start_op(1'b1, 1'b0, 32'd1, dummy);
        run(22);
        check("post_reset_ready_cycle", last_rdy - s0, 30);

        // Early exit: dp_zero_rem raised from cycle 5 of a multiply.
        clear_obs();
        start_op(1'b1, 1'b0, 32'd2, s0);
        run(4);
        dp_zero_rem = 1'b1;
        run(20);
        dp_zero_rem = 1'b0;
        check("early_exit_ready_cycle", last_rdy - s0, EARLY ? 6 : 18);
        run(2);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 249) == 0);
            r     = $urandom_range(0, 29);
            ctrl_MULT     = (r == 0) || (r == 2);
            ctrl_DIV      = (r == 1) || (r == 2) || (r == 3);
            data_operandB = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            dp_zero_rem   = ($urandom_range(0, 9) == 0);
            tick();
        end
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
